// File: rtl/id_ex.sv
// Pipeline register between decode and execute. It stalls on hold, inserts a NOP
// bubble on flush or invalid id, and forwards ex writebacks into captured or held operands.
module id_ex #(
   parameter logic [31:0] NOP_INST = 32'h00000013,
   parameter logic [15:0] NOP_CTRL = 16'h0000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [31:0] i_pc_addr,
   input  logic [31:0] i_inst_data,
   input  logic [4:0]  i_reg1_addr,
   input  logic [4:0]  i_reg2_addr,
   input  logic [31:0] i_reg1_data,
   input  logic [31:0] i_reg2_data,
   input  logic [4:0]  i_regd_addr,
   input  logic [31:0] i_imm_data,
   input  logic [15:0] i_ctrl,
   input  logic        i_id_valid,
   input  logic        i_hold,
   input  logic        i_flush,
   input  logic        i_wb_we,
   input  logic [4:0]  i_wb_addr,
   input  logic [31:0] i_wb_data,
   output logic [31:0] o_pc_addr,
   output logic [31:0] o_inst_data,
   output logic [31:0] o_reg1_data,
   output logic [31:0] o_reg2_data,
   output logic [4:0]  o_regd_addr,
   output logic [31:0] o_imm_data,
   output logic [15:0] o_ctrl,
   output logic        o_valid
);

   logic [31:0] pc_q, pc_d, inst_q, inst_d, reg1_q, reg1_d, reg2_q, reg2_d;
   logic [31:0] imm_q, imm_d;
   logic [4:0]  regd_q, regd_d, rs1_q, rs1_d, rs2_q, rs2_d;
   logic [15:0] ctrl_q, ctrl_d;
   logic        valid_q, valid_d;

   logic wb_live;
   assign wb_live = i_wb_we && (i_wb_addr != 5'd0);

   always_comb begin
      pc_d    = pc_q;
      inst_d  = inst_q;
      reg1_d  = reg1_q;
      reg2_d  = reg2_q;
      regd_d  = regd_q;
      imm_d   = imm_q;
      ctrl_d  = ctrl_q;
      valid_d = valid_q;
      rs1_d   = rs1_q;
      rs2_d   = rs2_q;
      if (i_flush || (!i_hold && !i_id_valid)) begin
         pc_d    = '0;
         inst_d  = NOP_INST;
         reg1_d  = '0;
         reg2_d  = '0;
         regd_d  = '0;
         imm_d   = '0;
         ctrl_d  = NOP_CTRL;
         valid_d = 1'b0;
         rs1_d   = '0;
         rs2_d   = '0;
      end else if (i_hold) begin
         // Stalled instruction still needs results retired by ex meanwhile.
         if (wb_live && (i_wb_addr == rs1_q)) reg1_d = i_wb_data;
         if (wb_live && (i_wb_addr == rs2_q)) reg2_d = i_wb_data;
      end else begin
         pc_d    = i_pc_addr;
         inst_d  = i_inst_data;
         reg1_d  = (wb_live && (i_wb_addr == i_reg1_addr)) ? i_wb_data : i_reg1_data;
         reg2_d  = (wb_live && (i_wb_addr == i_reg2_addr)) ? i_wb_data : i_reg2_data;
         regd_d  = i_regd_addr;
         imm_d   = i_imm_data;
         ctrl_d  = i_ctrl;
         valid_d = 1'b1;
         rs1_d   = i_reg1_addr;
         rs2_d   = i_reg2_addr;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         pc_q    <= '0;
         inst_q  <= NOP_INST;
         reg1_q  <= '0;
         reg2_q  <= '0;
         regd_q  <= '0;
         imm_q   <= '0;
         ctrl_q  <= NOP_CTRL;
         valid_q <= 1'b0;
         rs1_q   <= '0;
         rs2_q   <= '0;
      end else begin
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         reg1_q  <= reg1_d;
         reg2_q  <= reg2_d;
         regd_q  <= regd_d;
         imm_q   <= imm_d;
         ctrl_q  <= ctrl_d;
         valid_q <= valid_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
      end
   end

   assign o_pc_addr   = pc_q;
   assign o_inst_data = inst_q;
   assign o_reg1_data = reg1_q;
   assign o_reg2_data = reg2_q;
   assign o_regd_addr = regd_q;
   assign o_imm_data  = imm_q;
   assign o_ctrl      = ctrl_q;
   assign o_valid     = valid_q;

endmodule

// File: tb/tb_id_ex.sv
// Self-checking bench for id_ex: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural model of the register.
module tb_id_ex;

   logic        i_clk, i_reset;
   logic [31:0] i_pc_addr, i_inst_data, i_reg1_data, i_reg2_data, i_imm_data, i_wb_data;
   logic [4:0]  i_reg1_addr, i_reg2_addr, i_regd_addr, i_wb_addr;
   logic [15:0] i_ctrl;
   logic        i_id_valid, i_hold, i_flush, i_wb_we;
   logic [31:0] o_pc_addr, o_inst_data, o_reg1_data, o_reg2_data, o_imm_data;
   logic [4:0]  o_regd_addr;
   logic [15:0] o_ctrl;
   logic        o_valid;

   int total = 0;
   int bad   = 0;
   bit cmp_en = 0;

   id_ex dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_pc_addr(i_pc_addr), .i_inst_data(i_inst_data),
      .i_reg1_addr(i_reg1_addr), .i_reg2_addr(i_reg2_addr),
      .i_reg1_data(i_reg1_data), .i_reg2_data(i_reg2_data),
      .i_regd_addr(i_regd_addr), .i_imm_data(i_imm_data), .i_ctrl(i_ctrl),
      .i_id_valid(i_id_valid), .i_hold(i_hold), .i_flush(i_flush),
      .i_wb_we(i_wb_we), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
      .o_pc_addr(o_pc_addr), .o_inst_data(o_inst_data),
      .o_reg1_data(o_reg1_data), .o_reg2_data(o_reg2_data),
      .o_regd_addr(o_regd_addr), .o_imm_data(o_imm_data),
      .o_ctrl(o_ctrl), .o_valid(o_valid)
   );

   initial begin
      i_clk = 0;
      forever #5 i_clk = ~i_clk;
   end

   // What ex should see: the instruction in flight plus the rs addresses it depends on.
   typedef struct packed {
      logic [31:0] pc, inst, r1, r2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [15:0] ctrl;
      logic        v;
      logic [4:0]  a1, a2;
   } st_t;

   st_t m;

   function automatic st_t bubble();
      st_t b = '0;
      b.inst = 32'h00000013;
      b.ctrl = 16'h0000;
      return b;
   endfunction

   function automatic logic [31:0] fwd(logic [4:0] a, logic [31:0] d);
      return (i_wb_we && i_wb_addr != 0 && i_wb_addr == a) ? i_wb_data : d;
   endfunction

   function automatic st_t step_model(st_t c);
      st_t n;
      if (i_flush) return bubble();
      if (i_hold) begin
         n = c;
         n.r1 = fwd(c.a1, c.r1);
         n.r2 = fwd(c.a2, c.r2);
         return n;
      end
      if (!i_id_valid) return bubble();
      n = '{pc: i_pc_addr, inst: i_inst_data, r1: fwd(i_reg1_addr, i_reg1_data),
            r2: fwd(i_reg2_addr, i_reg2_data), rd: i_regd_addr, imm: i_imm_data,
            ctrl: i_ctrl, v: 1'b1, a1: i_reg1_addr, a2: i_reg2_addr};
      return n;
   endfunction

   always @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) m <= bubble();
      else          m <= step_model(m);
   end

   always @(negedge i_clk) begin
      if (cmp_en) begin
         total++;
         if ({o_pc_addr, o_inst_data, o_reg1_data, o_reg2_data, o_regd_addr, o_imm_data, o_ctrl, o_valid}
             !== {m.pc, m.inst, m.r1, m.r2, m.rd, m.imm, m.ctrl, m.v}) begin
            bad++;
            $display("FAIL model t=%0t got pc=%h inst=%h r1=%h r2=%h rd=%0d imm=%h ctrl=%h v=%b want pc=%h inst=%h r1=%h r2=%h rd=%0d imm=%h ctrl=%h v=%b",
                     $time, o_pc_addr, o_inst_data, o_reg1_data, o_reg2_data, o_regd_addr, o_imm_data, o_ctrl, o_valid,
                     m.pc, m.inst, m.r1, m.r2, m.rd, m.imm, m.ctrl, m.v);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end else begin
         $display("ok   %s = %h", name, got);
      end
   endtask

   task automatic idle();
      i_pc_addr = 0; i_inst_data = 0; i_reg1_addr = 0; i_reg2_addr = 0;
      i_reg1_data = 0; i_reg2_data = 0; i_regd_addr = 0; i_imm_data = 0; i_ctrl = 0;
      i_id_valid = 0; i_hold = 0; i_flush = 0; i_wb_we = 0; i_wb_addr = 0; i_wb_data = 0;
   endtask

   task automatic garbage();
      i_pc_addr = $urandom; i_inst_data = $urandom; i_reg1_addr = 5'($urandom);
      i_reg2_addr = 5'($urandom); i_reg1_data = $urandom; i_reg2_data = $urandom;
      i_regd_addr = 5'($urandom); i_imm_data = $urandom; i_ctrl = 16'($urandom);
   endtask

   task automatic cyc();
      @(negedge i_clk);
   endtask

   logic [31:0] pcs[8];

   initial begin
      idle();
      i_reset = 1;
      #1 i_reset = 0;
      #1 cmp_en = 1;
      repeat (2) cyc();
      i_reset = 1;
      // Release with the first instruction waiting.
      i_pc_addr = 32'h100; i_inst_data = 32'h00208133; i_ctrl = 16'h8000; i_id_valid = 1;
      cyc();
      chk("release_pc",   o_pc_addr,   32'h100);
      chk("release_inst", o_inst_data, 32'h00208133);
      chk("release_ctrl", {16'h0, o_ctrl}, 32'h8000);
      chk("release_v",    {31'h0, o_valid}, 32'h1);

      // Asynchronous reset mid-cycle.
      #2 i_reset = 0;
      #1;
      chk("areset_inst", o_inst_data, 32'h00000013);
      chk("areset_ctrl", {16'h0, o_ctrl}, 32'h0);
      chk("areset_v",    {31'h0, o_valid}, 32'h0);
      chk("areset_pc",   o_pc_addr, 32'h0);
      cyc();
      i_reset = 1;

      // Capture bypass on rs1, then x0 never bypassed.
      idle(); i_id_valid = 1; i_reg1_addr = 5; i_reg1_data = 32'h11;
      i_wb_we = 1; i_wb_addr = 5; i_wb_data = 32'hAA;
      cyc();
      chk("bypass_rs1", o_reg1_data, 32'hAA);
      i_reg1_addr = 0; i_reg1_data = 32'h33; i_wb_addr = 0; i_wb_data = 32'hBB;
      cyc();
      chk("bypass_x0", o_reg1_data, 32'h33);

      // Hold refresh of rs2 = x7.
      idle(); i_id_valid = 1; i_pc_addr = 32'h200; i_reg2_addr = 7; i_reg2_data = 32'h22;
      i_ctrl = 16'h8008;
      cyc();
      chk("hold_load", o_reg2_data, 32'h22);
      garbage(); i_hold = 1; i_id_valid = 1;
      i_wb_we = 1; i_wb_addr = 6; i_wb_data = 32'h99;
      cyc();
      chk("hold_c1_r2", o_reg2_data, 32'h22);
      chk("hold_c1_pc", o_pc_addr, 32'h200);
      i_wb_addr = 7; i_wb_data = 32'h55;
      cyc();
      chk("hold_c2_r2", o_reg2_data, 32'h55);
      i_wb_we = 0;
      cyc();
      chk("hold_c3_r2", o_reg2_data, 32'h55);
      chk("hold_c3_ctrl", {16'h0, o_ctrl}, 32'h8008);

      // Flush beats hold.
      i_flush = 1;
      cyc();
      chk("flush_ctrl", {16'h0, o_ctrl}, 32'h0);
      chk("flush_v",    {31'h0, o_valid}, 32'h0);
      chk("flush_inst", o_inst_data, 32'h00000013);

      // Invalid id with garbage.
      idle(); garbage(); i_id_valid = 0;
      cyc();
      chk("inval_v",    {31'h0, o_valid}, 32'h0);
      chk("inval_inst", o_inst_data, 32'h00000013);
      chk("inval_pc",   o_pc_addr, 32'h0);

      // Back-to-back stream of 8.
      for (int k = 0; k < 8; k++) begin
         idle(); garbage(); i_id_valid = 1;
         pcs[k] = 32'h1000 + 4 * k;
         i_pc_addr = pcs[k];
         cyc();
         chk($sformatf("stream%0d_pc", k), o_pc_addr, pcs[k]);
      end

      // Randomized run with a small register window so hits are frequent.
      for (int k = 0; k < 400; k++) begin
         garbage();
         i_reg1_addr = 5'($urandom_range(0, 3));
         i_reg2_addr = 5'($urandom_range(0, 3));
         i_id_valid  = ($urandom_range(0, 3) != 0);
         i_hold      = ($urandom_range(0, 3) == 0);
         i_flush     = ($urandom_range(0, 7) == 0);
         i_wb_we     = $urandom_range(0, 1) == 1;
         i_wb_addr   = 5'($urandom_range(0, 3));
         i_wb_data   = $urandom;
         if (k % 97 == 50) begin
            #3 i_reset = 0;
            cyc();
            i_reset = 1;
         end else begin
            cyc();
         end
      end

      cmp_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/id_ex.md
Name: id_ex

Overview:
- Pipeline register between the decode stage (id) and the combinational execute stage (ex).
- Captures decoded instruction fields and register operands each cycle, then presents them to ex.
- Obeys stall (hold) and flush requests from hold_ctrl, injecting a NOP bubble on flush.
- Refreshes held operands while stalled, so a register write retired by ex during a stall is not lost to the waiting instruction.

Parameters:
- NOP_INST, 32'h00000013, instruction word presented on bubble (addi x0,x0,0)
- NOP_CTRL, 16'h0000, control bundle presented on bubble: no reg write, no mem write, no branch

Ports:
- i_clk  input  1  clock, rising-edge
- i_reset  input  1  asynchronous reset, active-low
- i_pc_addr  input  32  pc of decoded instruction
- i_inst_data  input  32  decoded instruction word
- i_reg1_addr  input  5  rs1 address
- i_reg2_addr  input  5  rs2 address
- i_reg1_data  input  32  rs1 data from regs
- i_reg2_data  input  32  rs2 data from regs
- i_regd_addr  input  5  rd address
- i_imm_data  input  32  immediate
- i_ctrl  input  16  control bundle; bit15 REG_we, bit3 MEM_we, bits7:5 BRANCH
- i_id_valid  input  1  id holds a real instruction
- i_hold  input  1  stall request from hold_ctrl
- i_flush  input  1  flush request from hold_ctrl (jump taken)
- i_wb_we  input  1  ex rd write enable (ex o_regd_we)
- i_wb_addr  input  5  ex rd write address
- i_wb_data  input  32  ex rd write data
- o_pc_addr  output  32  to ex
- o_inst_data  output  32  to ex
- o_reg1_data  output  32  to ex
- o_reg2_data  output  32  to ex
- o_regd_addr  output  5  to ex
- o_imm_data  output  32  to ex
- o_ctrl  output  16  to ex
- o_valid  output  1  ex holds a real instruction

Behaviour:
- Reset (i_reset=0, asynchronous):
  - o_inst_data=NOP_INST, o_ctrl=NOP_CTRL, o_valid=0.
  - All other outputs = 0.
  - Also held internally: 5-bit rs1/rs2 address registers, reset to 0.
- Release: the first capture occurs on the first rising edge with i_reset=1.
- Per-edge priority is flush > hold > load.
  - Flush: load the bubble (reset values of all outputs and internal rs addresses). This holds even if i_hold=1 in the same cycle, because a jump kills the instruction in id.
  - Hold (i_hold=1, i_flush=0): keep all fields except operand refresh. For each held operand n (1, 2): if i_wb_we=1, i_wb_addr!=0 and i_wb_addr==held rsN addr, then o_regN_data<=i_wb_data; otherwise keep the value.
  - Load (i_hold=0, i_flush=0): capture all inputs; o_valid<=i_id_valid. Operand capture bypass: if i_wb_we=1, i_wb_addr!=0 and i_wb_addr==i_regN_addr, capture i_wb_data instead of i_regN_data.
  - Load with i_id_valid=0: capture the bubble instead of the inputs.
- Address x0 is never bypassed or refreshed. Held data for x0 stays as captured (regs returns 0).
- Latency: one cycle, id input to ex output. No combinational path from any input to any output.
- Refresh and bypass use the write present in the same cycle as the edge. If rs1 and rs2 both match, both are updated.
- Flush applies to the instruction in this register on the next edge only; there is no multi-cycle state.
- Reset asserted mid-stall or mid-flush forces the bubble immediately, independent of i_clk.

Test Plan:
- Reset / release:
  - Assert i_reset=0 mid-cycle -> outputs immediately become inst=0x00000013, ctrl=0x0000, o_valid=0.
  - Release, apply pc=0x100, inst=0x00208133, ctrl=0x8000, i_id_valid=1 -> the next edge shows identical values, o_valid=1.
- Capture bypass:
  - rs1=5, i_reg1_data=0x11, i_wb_we=1, i_wb_addr=5, i_wb_data=0xAA, load -> o_reg1_data=0xAA.
  - Repeat with i_wb_addr=0 and rs1=0 -> captures i_reg1_data.
- Hold refresh:
  - Load rs2=7, data 0x22.
  - Hold 3 cycles, with a write x7=0x55 on cycle 2 -> o_reg2_data=0x22 before that edge and 0x55 after. All other outputs unchanged throughout.
- Flush priority: i_hold=1 and i_flush=1 on the same edge with a valid instruction held -> bubble (ctrl=0, o_valid=0).
- Invalid id: i_id_valid=0 with garbage inputs, load -> bubble presented, o_valid=0.
- Back-to-back stream: 8 consecutive instructions with no hold/flush -> each appears exactly one cycle later, in order, with no drops or duplicates.
